// File: rtl/fft_bus_master.sv
// fft_bus_master: bus initiator that loads 16 samples into the FFT peripheral
// and streams the result words back out over a valid/ready interface.
//
// Ports:
//   mclk, puc_rst_n            clock, synchronous active-low reset
//   start                      frame start pulse (ignored while busy)
//   smp_data/valid/ready       sample input stream
//   res_data/idx/valid/ready   result output stream
//   busy, done                 frame status, done is a one-cycle pulse
//   per_addr/din/en/we/dout    peripheral bus (dout valid same cycle as en)
//
// Build option: FFT_MASTER_PRESCALE_EN divides each sample by 4 (arithmetic
// shift) before writing it, giving the FFT 12 dB of overflow headroom.

module fft_bus_master #(
    parameter logic [13:0] WR_ADDR     = 14'h0A0,
    parameter logic [13:0] RD_BASE     = 14'h088,
    parameter int          NUM_SAMPLES = 16,
    parameter int          NUM_RESULTS = 18
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic        start,
    input  logic [15:0] smp_data,
    input  logic        smp_valid,
    output logic        smp_ready,
    output logic [15:0] res_data,
    output logic [4:0]  res_idx,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic        done,
    output logic [13:0] per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_we,
    input  logic [15:0] per_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_READ,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  wr_cnt;
    logic [4:0]  wr_cnt_nxt;
    logic [4:0]  rd_idx;
    logic [4:0]  rd_idx_nxt;
    logic        last_smp;
    logic        last_res;
    logic        res_hs;
    logic        wr_issue;
    logic        rd_issue;
    logic [15:0] smp_scaled;

`ifdef FFT_MASTER_PRESCALE_EN
    assign smp_scaled = $signed(smp_data) >>> 2;
`else
    assign smp_scaled = smp_data;
`endif

    assign last_smp = (wr_cnt == 5'(NUM_SAMPLES - 1));
    assign last_res = (rd_idx == 5'(NUM_RESULTS - 1));
    assign res_hs   = res_valid & res_ready;

    // A write goes out the cycle after each accepted sample; a read is set
    // up on the edge that enters READ so it is on the bus during READ.
    assign wr_issue = (state == S_LOAD) & smp_valid;
    assign rd_issue = (state_nxt == S_READ);

    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state  <= S_IDLE;
            wr_cnt <= '0;
            rd_idx <= '0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_cnt_nxt;
            rd_idx <= rd_idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_idx_nxt = rd_idx;
        smp_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    wr_cnt_nxt = '0;
                    rd_idx_nxt = '0;
                    state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                smp_ready = 1'b1;
                if (smp_valid) begin
                    wr_cnt_nxt = wr_cnt + 5'd1;
                    if (last_smp) state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: state_nxt = S_READ;
            S_READ:   state_nxt = S_HOLD;
            S_HOLD: begin
                if (res_hs) begin
                    if (last_res) begin
                        state_nxt = S_DONE;
                    end else begin
                        rd_idx_nxt = rd_idx + 5'd1;
                        state_nxt  = S_READ;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus cycle registers: zero unless a write or read is issued.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            per_en   <= 1'b0;
            per_we   <= 2'b00;
            per_addr <= '0;
            per_din  <= '0;
        end else begin
            per_en   <= 1'b0;
            per_we   <= 2'b00;
            per_addr <= '0;
            per_din  <= '0;
            unique case (1'b1)
                wr_issue: begin
                    per_en   <= 1'b1;
                    per_we   <= 2'b11;
                    per_addr <= WR_ADDR;
                    per_din  <= smp_scaled;
                end
                rd_issue: begin
                    per_en   <= 1'b1;
                    per_addr <= RD_BASE + 14'(rd_idx_nxt);
                end
                default: ;
            endcase
        end
    end

    // Result register: captured at the end of READ, cleared on consumption
    // so the result outputs read 0 whenever nothing is pending.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
        end else if (state == S_READ) begin
            res_valid <= 1'b1;
            res_data  <= per_dout;
            res_idx   <= rd_idx;
        end else if (res_hs) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
        end
    end

endmodule

// File: tb/tb_fft_bus_master.sv
// tb_fft_bus_master: self-checking bench for fft_bus_master.
// Scoreboard model of the FFT bus plus table and corner-case sequences.

module tb_fft_bus_master;

    localparam logic [13:0] WR_ADDR = 14'h0A0;
    localparam logic [13:0] RD_BASE = 14'h088;

    logic        mclk = 1'b0;
    logic        puc_rst_n;
    logic        start;
    logic [15:0] smp_data;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] res_data;
    logic [4:0]  res_idx;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    always #5 mclk = ~mclk;

    fft_bus_master dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .start     (start),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout)
    );

    // Peripheral read data: an arbitrary per-address pattern.
    function automatic logic [15:0] bus_model(input logic [13:0] a);
        return (16'(a) * 16'h0101) ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] scale(input logic [15:0] s);
`ifdef FFT_MASTER_PRESCALE_EN
        return {{2{s[15]}}, s[15:2]};
`else
        return s;
`endif
    endfunction

    assign per_dout = (per_en && per_we == 2'b00) ? bus_model(per_addr) : 16'h0;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int frame_base = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic tick;
        @(posedge mclk);
        #1;
        cyc++;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {smp_ready, res_valid, res_data, res_idx, busy, done,
                 per_en, per_we, per_addr, per_din}, 64'h0);
    endtask

    // Bus / stream monitor, sampled mid-cycle.
    logic [29:0] wr_q[$];
    logic [13:0] rd_q[$];
    logic [20:0] res_q[$];
    int done_cnt, done_rel, first_wr, last_wr, first_rd, first_rv;
    int wr_run, wr_run_max, rd_consec, rel;
    bit prev_rd;

    always @(negedge mclk) begin
        rel = cyc - frame_base + 1;
        if (per_en && per_we == 2'b11) begin
            wr_q.push_back({per_addr, per_din});
            if (first_wr < 0) first_wr = rel;
            last_wr = rel;
            wr_run++;
            if (wr_run > wr_run_max) wr_run_max = wr_run;
        end else begin
            wr_run = 0;
        end
        if (per_en && per_we == 2'b00) begin
            rd_q.push_back(per_addr);
            if (prev_rd) rd_consec++;
            if (first_rd < 0) first_rd = rel;
        end
        prev_rd = per_en && per_we == 2'b00;
        if (res_valid && first_rv < 0) first_rv = rel;
        if (res_valid && res_ready) res_q.push_back({res_idx, res_data});
        if (done) begin
            done_cnt++;
            done_rel = rel;
        end
    end

    logic [15:0] cur_smp[16];
    int bp_cnt;
    bit aborted;

    // vmode: 0 held, 1 toggling, 2 random. rmode: 0 held, 1 random.
    task automatic run_frame(input int vmode, input int rmode, input bit bp,
                             input int abort_idx, input bit rstart);
        int si;
        int ph;
        bit hs_s;
        bit bp_hold;
        bit seen_done;
        wr_q.delete();
        rd_q.delete();
        res_q.delete();
        done_cnt = 0; first_wr = -1; last_wr = -1; first_rd = -1;
        first_rv = -1; wr_run = 0; wr_run_max = 0; rd_consec = 0;
        bp_cnt = 0; aborted = 0; seen_done = 0; si = 0; ph = 0;
        start = 1'b1; smp_valid = 1'b0; res_ready = 1'b0;
        tick;
        start = 1'b0;
        frame_base = cyc;
        chk("ready_cycle1", {smp_ready, busy}, 2'b11);
        for (int b = 0; b < 600 && !seen_done; b++) begin
            case (vmode)
                0:       smp_valid = 1'b1;
                1:       smp_valid = (ph % 2 == 0);
                default: smp_valid = ($urandom_range(0, 3) != 0);
            endcase
            smp_data = (si < 16) ? cur_smp[si] : 16'hDEAD;
            ph++;
            res_ready = (rmode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
            bp_hold = bp && res_valid && res_idx == 5'd3 && bp_cnt < 5;
            if (bp_hold) res_ready = 1'b0;
            start = rstart && busy && (ph % 5 == 2);
            hs_s = smp_valid && smp_ready;
            if (abort_idx >= 0 && per_en && per_we == 2'b00 &&
                per_addr == RD_BASE + 14'(abort_idx)) begin
                puc_rst_n = 1'b0;
                start = 1'b0;
                tick;
                chk_zero("abort_zero");
                puc_rst_n = 1'b1;
                smp_valid = 1'b0;
                res_ready = 1'b0;
                tick;
                aborted = 1;
                return;
            end
            tick;
            if (hs_s) si++;
            if (bp_hold) begin
                chk("bp_valid", res_valid, 1);
                chk("bp_idx", res_idx, 3);
                chk("bp_data", res_data, bus_model(RD_BASE + 14'd3));
                chk("bp_no_read", per_en, 0);
                bp_cnt++;
            end
            if (done) seen_done = 1;
        end
        start = 1'b0; smp_valid = 1'b0; res_ready = 1'b0;
        chk("frame_timeout", seen_done, 1);
        tick;
        chk("idle_after", busy, 0);
        chk("done_once", done_cnt, 1);
        chk("no_consec_rd", rd_consec, 0);
        chk("wr_count", wr_q.size(), 16);
        foreach (wr_q[i])
            if (i < 16) chk("wr_word", wr_q[i], {WR_ADDR, scale(cur_smp[i])});
        chk("rd_count", rd_q.size(), 18);
        foreach (rd_q[i]) chk("rd_addr", rd_q[i], RD_BASE + 14'(i));
        chk("res_count", res_q.size(), 18);
        foreach (res_q[i])
            chk("res_word", res_q[i], {5'(i), bus_model(RD_BASE + 14'(i))});
    endtask

    typedef struct {
        logic [15:0] smp;
        logic [15:0] exp_din;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        puc_rst_n = 1'b0; start = 1'b1; smp_valid = 1'b1;
        smp_data = 16'h1111; res_ready = 1'b0;
        repeat (3) begin
            tick;
            chk_zero("reset_zero");
        end
        puc_rst_n = 1'b1; start = 1'b0;
        repeat (3) tick;
        chk_zero("idle_valid_ignored");
        smp_valid = 1'b0; res_ready = 1'b1;
        tick;
        chk_zero("idle_ready_ignored");

        // Impulse frame, continuous valid/ready.
        foreach (cur_smp[i]) cur_smp[i] = (i == 0) ? 16'h4000 : 16'h0000;
        run_frame(0, 0, 0, -1, 0);
        chk("first_write", first_wr, 2);
        chk("last_write", last_wr, 17);
        chk("first_read", first_rd, 18);
        chk("first_res_valid", first_rv, 19);
        chk("frame_len", done_rel + 1, 55);

        // Table frame: fixed sample -> per_din pairs.
`ifdef FFT_MASTER_PRESCALE_EN
        tbl[0] = '{16'h8000, 16'hE000};
        tbl[1] = '{16'h7FFF, 16'h1FFF};
        tbl[2] = '{16'hFFFF, 16'hFFFF};
        tbl[3] = '{16'h0004, 16'h0001};
        tbl[4] = '{16'hFFFC, 16'hFFFF};
        tbl[5] = '{16'h1234, 16'h048D};
        for (int i = 6; i < 16; i++) tbl[i] = '{16'(i * 4), 16'(i)};
`else
        tbl[0] = '{16'h8000, 16'h8000};
        tbl[1] = '{16'h7FFF, 16'h7FFF};
        tbl[2] = '{16'hFFFF, 16'hFFFF};
        tbl[3] = '{16'h0004, 16'h0004};
        tbl[4] = '{16'hFFFC, 16'hFFFC};
        tbl[5] = '{16'h1234, 16'h1234};
        for (int i = 6; i < 16; i++) tbl[i] = '{16'(i * 4), 16'(i * 4)};
`endif
        foreach (tbl[i]) cur_smp[i] = tbl[i].smp;
        run_frame(0, 0, 0, -1, 0);
        for (int i = 0; i < 16; i++)
            if (i < wr_q.size()) chk("tbl_din", wr_q[i][15:0], tbl[i].exp_din);

        // Throttled source with start pulses during the frame.
        foreach (cur_smp[i]) cur_smp[i] = 16'($urandom);
        run_frame(1, 0, 0, -1, 1);
        chk("throttle_gaps", wr_run_max, 1);

        // Backpressure on result 3.
        foreach (cur_smp[i]) cur_smp[i] = 16'($urandom);
        run_frame(0, 0, 1, -1, 0);
        chk("bp_cycles", bp_cnt, 5);

        // Abort during read 7, then a full restart.
        run_frame(0, 0, 0, 7, 0);
        chk("aborted", aborted, 1);
        foreach (cur_smp[i]) cur_smp[i] = 16'($urandom);
        run_frame(2, 1, 0, -1, 0);

        // Random frames.
        repeat (4) begin
            foreach (cur_smp[i]) cur_smp[i] = 16'($urandom);
            run_frame(2, 1, 0, -1, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
